issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 16 +
 rtl/issue_ctrl_scoreboard.sv | 42 ++++
 rtl/issue_ctrl.sv | 122 ++++++++++++
 tb/tb_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the in-order issue controller.
//   MAX_INFLIGHT  : number of long-latency writers allowed in flight at once
//   INFLIGHT_W    : width of the in-flight counter (must hold 0..MAX_INFLIGHT)
//   issue_state_t : controller FSM states
package issue_ctrl_pkg;

  localparam int MAX_INFLIGHT = 4;
  localparam int INFLIGHT_W   = 3;

  typedef enum logic [1:0] {
    RUN,    // normal issue
    DRAIN,  // waiting for in-flight ops to retire before a serializing instr
    FLUSH   // one dead cycle after a pipeline flush
  } issue_state_t;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// long-latency writer issues and cleared by its writeback.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   set_en, set_idx     : mark register set_idx as pending
//   clr_en, clr_idx     : retire the pending write to register clr_idx
//   flush               : clear every pending bit (wins over set/clear)
//   sb                  : registered pending bits, bit 0 always 0
module scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic        flush,
  output logic [31:0] sb
);

  logic [31:0] sb_q;
  logic [31:0] sb_d;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned; that is what keeps this block from inferring a latch.
  always_comb begin
    sb_d = sb_q;
    if (set_en) sb_d[set_idx] = 1'b1;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    sb_d[0] = 1'b0;                // x0 is never pending
    if (flush) sb_d = '0;
  end

  // NOTE: the table is only 32 flops, so it is reset like any other state;
  // a reset or flush must never leave a stale pending bit behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign sb = sb_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: checks decoded instructions against the
// pending-write scoreboard, limits long-latency ops in flight, drains the
// pipeline for serializing instructions and handles flushes.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   dec_valid_i / dec_ready_o        : decode -> issue handshake
//   dec_rd_v_i,  dec_rd_i            : destination register usage
//   dec_rs1_v_i, dec_rs1_i           : source 1 register usage
//   dec_rs2_v_i, dec_rs2_i           : source 2 register usage
//   dec_is_load_i                    : instr is a long-latency writer
//   dec_serialize_i                  : instr needs zero ops in flight
//   exe_valid_o / exe_ready_i        : issue -> execute handshake
//   wb_valid_i, wb_rd_i              : long-latency writeback
//   flush_i                          : pipeline flush
//   scoreboard_o                     : pending-write bits
//   inflight_o                       : long-latency ops in flight
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic        dec_rd_v_i,
  input  logic [4:0]  dec_rd_i,
  input  logic        dec_rs1_v_i,
  input  logic [4:0]  dec_rs1_i,
  input  logic        dec_rs2_v_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic        dec_is_load_i,
  input  logic        dec_serialize_i,
  output logic        exe_valid_o,
  input  logic        exe_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic [31:0] scoreboard_o,
  output logic [2:0]  inflight_o
);

  issue_state_t          state_q, state_d;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic [31:0]           sb;

  logic hazard;
  logic slot_ok;
  logic serial_ok;
  logic can_issue;
  logic issue;
  logic load_set;
  logic wb_clr;
  logic inflight_nz;

  assign inflight_nz = (inflight_q != '0);

  // Registered scoreboard only: a writeback in this cycle does not unblock a
  // dependent instr until the following cycle.
  assign hazard = (dec_rs1_v_i & sb[dec_rs1_i]) |
                  (dec_rs2_v_i & sb[dec_rs2_i]) |
                  (dec_rd_v_i  & sb[dec_rd_i]);

  assign slot_ok   = (inflight_q < INFLIGHT_W'(MAX_INFLIGHT)) | ~dec_is_load_i;
  assign serial_ok = ~(dec_serialize_i & inflight_nz);
  assign can_issue = (state_q == RUN) & ~hazard & ~flush_i & slot_ok & serial_ok;

  // Both handshake outputs are held low while reset is asserted.
  assign exe_valid_o = ~reset & dec_valid_i & can_issue;
  assign dec_ready_o = ~reset & exe_ready_i & can_issue;

  assign issue    = dec_valid_i & dec_ready_o;
  assign load_set = issue & dec_is_load_i & dec_rd_v_i & (dec_rd_i != 5'd0);
  // Spurious writebacks (not pending, or nothing in flight) are dropped.
  assign wb_clr   = wb_valid_i & sb[wb_rd_i] & inflight_nz;

  scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (load_set),
    .set_idx (dec_rd_i),
    .clr_en  (wb_clr),
    .clr_idx (wb_rd_i),
    .flush   (flush_i),
    .sb      (sb)
  );

  always_comb begin
    inflight_d = inflight_q;
    case ({load_set, wb_clr})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;  // none, or set and clear cancel out
    endcase
    if (flush_i) inflight_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (dec_valid_i & dec_serialize_i & inflight_nz) state_d = DRAIN;
      DRAIN:   if (!inflight_nz) state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush_i) state_d = FLUSH;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  assign scoreboard_o = sb;
  assign inflight_o   = inflight_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid_i, dec_ready_o;
  logic        dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i;
  logic [4:0]  dec_rd_i, dec_rs1_i, dec_rs2_i;
  logic        dec_is_load_i, dec_serialize_i;
  logic        exe_valid_o, exe_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic [31:0] scoreboard_o;
  logic [2:0]  inflight_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .dec_valid_i     (dec_valid_i),
    .dec_ready_o     (dec_ready_o),
    .dec_rd_v_i      (dec_rd_v_i),
    .dec_rd_i        (dec_rd_i),
    .dec_rs1_v_i     (dec_rs1_v_i),
    .dec_rs1_i       (dec_rs1_i),
    .dec_rs2_v_i     (dec_rs2_v_i),
    .dec_rs2_i       (dec_rs2_i),
    .dec_is_load_i   (dec_is_load_i),
    .dec_serialize_i (dec_serialize_i),
    .exe_valid_o     (exe_valid_o),
    .exe_ready_i     (exe_ready_i),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_i         (wb_rd_i),
    .flush_i         (flush_i),
    .scoreboard_o    (scoreboard_o),
    .inflight_o      (inflight_o)
  );

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic rdv, input logic [4:0] rd,
                         input logic r1v, input logic [4:0] r1,
                         input logic r2v, input logic [4:0] r2,
                         input logic ld, input logic ser);
    dec_valid_i = v;  dec_rd_v_i = rdv; dec_rd_i = rd;
    dec_rs1_v_i = r1v; dec_rs1_i = r1; dec_rs2_v_i = r2v; dec_rs2_i = r2;
    dec_is_load_i = ld; dec_serialize_i = ser;
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd);
    wb_valid_i = v; wb_rd_i = rd;
    #1;
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; exe_ready_i = 1'b1; flush_i = 1'b0;
    set_wb(0, 0);
    set_dec(1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(); step();
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL rst_exe_valid got %0b exp 0", exe_valid_o); end
    checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL rst_dec_ready got %0b exp 0", dec_ready_o); end
    checks++; if (scoreboard_o !== 32'h0) begin errors++; $display("FAIL rst_sb got %h exp 0", scoreboard_o); end
    checks++; if (inflight_o !== 3'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", inflight_o); end
    reset = 1'b0;
    #1;
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL rst_first_issue got %0b exp 1", exe_valid_o); end
    step();
    idle();
  endtask

  task automatic test_load_use();
    set_dec(1, 1, 5, 0, 0, 0, 0, 1, 0);
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL lu_load_issue got %0b exp 1", exe_valid_o); end
    step();
    checks++; if (scoreboard_o !== 32'h20) begin errors++; $display("FAIL lu_sb_set got %h exp 00000020", scoreboard_o); end
    checks++; if (inflight_o !== 3'd1) begin errors++; $display("FAIL lu_inflight_1 got %0d exp 1", inflight_o); end
    set_dec(1, 1, 6, 1, 5, 0, 0, 0, 0);
    checks++; if (exe_valid_o !== 1'b0 || dec_ready_o !== 1'b0) begin errors++; $display("FAIL lu_stall got %0b/%0b exp 0/0", exe_valid_o, dec_ready_o); end
    step();
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %0b exp 0", exe_valid_o); end
    set_wb(1, 5);
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL lu_no_bypass got %0b exp 0", exe_valid_o); end
    step();
    set_wb(0, 0);
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL lu_issue_after_wb got %0b exp 1", exe_valid_o); end
    checks++; if (inflight_o !== 3'd0 || scoreboard_o !== 32'h0) begin errors++; $display("FAIL lu_retired got inflight %0d sb %h exp 0 0", inflight_o, scoreboard_o); end
    step();
    idle();
  endtask

  task automatic test_handshake();
    exe_ready_i = 1'b0;
    set_dec(1, 1, 8, 0, 0, 0, 0, 1, 0);
    checks++; if (exe_valid_o !== 1'b1 || dec_ready_o !== 1'b0) begin errors++; $display("FAIL hs_not_ready got %0b/%0b exp 1/0", exe_valid_o, dec_ready_o); end
    step();
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL hs_no_issue got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
    exe_ready_i = 1'b1;
    #1;
    step();
    checks++; if (scoreboard_o !== 32'h100) begin errors++; $display("FAIL hs_issued got %h exp 00000100", scoreboard_o); end
    // WAW on rd=8 and RAW through rs2 both block.
    set_dec(1, 1, 8, 0, 0, 0, 0, 1, 0);
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL hs_waw got %0b exp 0", exe_valid_o); end
    set_dec(1, 1, 9, 0, 0, 1, 8, 0, 0);
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL hs_raw_rs2 got %0b exp 0", exe_valid_o); end
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 8);
    step();
    idle();
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL hs_clean got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 4; i++) begin
      set_dec(1, 1, 5'(i), 0, 0, 0, 0, 1, 0);
      step();
    end
    checks++; if (inflight_o !== 3'd4 || scoreboard_o !== 32'h1E) begin errors++; $display("FAIL sat_full got inflight %0d sb %h exp 4 0000001e", inflight_o, scoreboard_o); end
    set_dec(1, 1, 6, 0, 0, 0, 0, 1, 0);
    checks++; if (dec_ready_o !== 1'b0 || exe_valid_o !== 1'b0) begin errors++; $display("FAIL sat_hold got %0b/%0b exp 0/0", dec_ready_o, exe_valid_o); end
    step();
    checks++; if (dec_ready_o !== 1'b0 || inflight_o !== 3'd4) begin errors++; $display("FAIL sat_hold2 got ready %0b inflight %0d exp 0 4", dec_ready_o, inflight_o); end
    set_dec(1, 1, 7, 1, 7, 0, 0, 0, 0);
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL sat_nonload got %0b exp 1", exe_valid_o); end
    step();
    set_dec(1, 1, 6, 0, 0, 0, 0, 1, 0);
    set_wb(1, 1);
    checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL sat_wb_cycle got %0b exp 0", dec_ready_o); end
    step();
    set_wb(0, 0);
    checks++; if (inflight_o !== 3'd3 || dec_ready_o !== 1'b1) begin errors++; $display("FAIL sat_release got inflight %0d ready %0b exp 3 1", inflight_o, dec_ready_o); end
    step();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (inflight_o !== 3'd4 || scoreboard_o !== 32'h5C) begin errors++; $display("FAIL sat_fifth got inflight %0d sb %h exp 4 0000005c", inflight_o, scoreboard_o); end
    set_wb(1, 2); step();
    set_wb(1, 3); step();
    set_wb(1, 4); step();
    checks++; if (inflight_o !== 3'd1 || scoreboard_o !== 32'h40) begin errors++; $display("FAIL sat_drain got inflight %0d sb %h exp 1 00000040", inflight_o, scoreboard_o); end
    set_wb(1, 6); step();
    idle();
    checks++; if (inflight_o !== 3'd0 || scoreboard_o !== 32'h0) begin errors++; $display("FAIL sat_clean got inflight %0d sb %h exp 0 0", inflight_o, scoreboard_o); end
  endtask

  task automatic test_serialize();
    set_dec(1, 1, 10, 0, 0, 0, 0, 1, 0); step();
    set_dec(1, 1, 11, 0, 0, 0, 0, 1, 0); step();
    checks++; if (inflight_o !== 3'd2) begin errors++; $display("FAIL ser_two_loads got %0d exp 2", inflight_o); end
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL ser_blocked got %0b exp 0", exe_valid_o); end
    step();
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL ser_drain0 got %0b exp 0", exe_valid_o); end
    set_wb(1, 10); step();
    checks++; if (exe_valid_o !== 1'b0 || inflight_o !== 3'd1) begin errors++; $display("FAIL ser_drain1 got valid %0b inflight %0d exp 0 1", exe_valid_o, inflight_o); end
    set_wb(1, 11); step();
    set_wb(0, 0);
    // inflight just reached 0; still in DRAIN for this cycle.
    checks++; if (exe_valid_o !== 1'b0 || inflight_o !== 3'd0) begin errors++; $display("FAIL ser_drain2 got valid %0b inflight %0d exp 0 0", exe_valid_o, inflight_o); end
    step();
    checks++; if (exe_valid_o !== 1'b1 || dec_ready_o !== 1'b1) begin errors++; $display("FAIL ser_csr_issue got %0b/%0b exp 1/1", exe_valid_o, dec_ready_o); end
    step();
    idle();
  endtask

  task automatic test_flush();
    set_dec(1, 1, 3, 0, 0, 0, 0, 1, 0); step();
    set_dec(1, 1, 9, 0, 0, 0, 0, 1, 0); step();
    checks++; if (scoreboard_o !== 32'h208 || inflight_o !== 3'd2) begin errors++; $display("FAIL fl_setup got sb %h inflight %0d exp 00000208 2", scoreboard_o, inflight_o); end
    set_dec(1, 1, 20, 0, 0, 0, 0, 0, 0);
    flush_i = 1'b1;
    set_wb(1, 3);
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL fl_blocks_issue got %0b exp 0", exe_valid_o); end
    step();
    flush_i = 1'b0;
    set_wb(0, 0);
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL fl_cleared got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
    checks++; if (exe_valid_o !== 1'b0) begin errors++; $display("FAIL fl_state_flush got %0b exp 0", exe_valid_o); end
    step();
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL fl_back_to_run got %0b exp 1", exe_valid_o); end
    step();
    idle();
  endtask

  task automatic test_x0_spurious();
    set_dec(1, 1, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL x0_issue got %0b exp 1", exe_valid_o); end
    step();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL x0_no_track got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
    set_wb(1, 12); step();
    set_wb(0, 0);
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL wb_no_underflow got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
    set_dec(1, 1, 13, 0, 0, 0, 0, 1, 0); step();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 12); step();
    set_wb(0, 0);
    checks++; if (scoreboard_o !== 32'h2000 || inflight_o !== 3'd1) begin errors++; $display("FAIL wb_not_pending got sb %h inflight %0d exp 00002000 1", scoreboard_o, inflight_o); end
    set_wb(1, 13); step();
    set_wb(0, 0);
    // Serializing instr with nothing in flight issues at once.
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (exe_valid_o !== 1'b1) begin errors++; $display("FAIL ser_empty_issue got %0b exp 1", exe_valid_o); end
    step();
    idle();
  endtask

  task automatic test_reset_drain();
    set_dec(1, 1, 20, 0, 0, 0, 0, 1, 0); step();
    set_dec(1, 0, 0, 0, 0, 0, 0, 0, 1); step();
    checks++; if (exe_valid_o !== 1'b0 || inflight_o !== 3'd1) begin errors++; $display("FAIL rd_in_drain got valid %0b inflight %0d exp 0 1", exe_valid_o, inflight_o); end
    reset = 1'b1;
    #1;
    checks++; if (exe_valid_o !== 1'b0 || dec_ready_o !== 1'b0) begin errors++; $display("FAIL rd_outputs got %0b/%0b exp 0/0", exe_valid_o, dec_ready_o); end
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL rd_state got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (exe_valid_o !== 1'b1 || dec_ready_o !== 1'b1) begin errors++; $display("FAIL rd_run_after got %0b/%0b exp 1/1", exe_valid_o, dec_ready_o); end
    step();
    idle();
    checks++; if (scoreboard_o !== 32'h0 || inflight_o !== 3'd0) begin errors++; $display("FAIL rd_final got sb %h inflight %0d exp 0 0", scoreboard_o, inflight_o); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_handshake();
    test_saturation();
    test_serialize();
    test_flush();
    test_x0_spurious();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
